jbi_min_rq_rdq_issue: RTL
=========================

JBI_MIN_RQ_RDQ_ISSUE -- requirements
Module: jbi_min_rq_rdq_issue

Interface
REQ-001 The block SHALL have one clock and SHALL use an asynchronous, active-high reset; all state SHALL be clocked by clk.
REQ-002 Constant JBI_RQ_CREDITS, default 4, SHALL set the maximum number of requests outstanding at SCTAG.
REQ-003 Constant JBI_RDQ_WIDTH, default 64, SHALL set the RDQ header width.
REQ-004 clk  in  1  cpu-domain clock.
REQ-005 rst  in  1  asynchronous reset, active-high.
REQ-006 rdq_rd_en  in  1  RDQ holds a readable head entry.
REQ-007 rdq_dout  in  JBI_RDQ_WIDTH  head-entry header, valid while rdq_rd_en=1.
REQ-008 csr_issue_stall  in  1  software stall; blocks new issue.
REQ-009 sctag_credit_ret  in  1  one-cycle pulse returning one credit.
REQ-010 issue_rdq_pop  out  1  one-cycle pulse that pops the RDQ head.
REQ-011 sctag_req_vld  out  1  request valid to SCTAG, one cycle per request.
REQ-012 sctag_req  out  JBI_RDQ_WIDTH  request header, registered.
REQ-013 credit_cnt  out  3  credits currently available.
REQ-014 credit_err  out  1  sticky credit overflow or underflow flag.

Function
REQ-015 The FSM SHALL have two states: IDLE and ISSUE.
REQ-016 In IDLE, when rdq_rd_en=1, credit_cnt>0 and csr_issue_stall=0, issue_rdq_pop SHALL be 1 that cycle.
REQ-017 In that same IDLE cycle, sctag_req SHALL load rdq_dout at the clock edge, and the FSM SHALL go to ISSUE.
REQ-018 If any of the three conditions in REQ-016 is false, IDLE SHALL hold and issue_rdq_pop SHALL be 0.
REQ-019 In ISSUE, sctag_req_vld SHALL be 1 for exactly one cycle and the FSM SHALL return to IDLE unconditionally.
REQ-020 Latency from the pop cycle to sctag_req_vld SHALL be 1 cycle.
REQ-021 Peak throughput SHALL be one request per 2 cycles; the ISSUE cycle is the gap that lets the RDQ read data settle.
REQ-022 sctag_req SHALL hold its value when not loading and SHALL only change on a pop.
REQ-023 credit_cnt SHALL decrement by 1 on a pop and increment by 1 on sctag_credit_ret.
REQ-024 When a pop and sctag_credit_ret occur in the same cycle, credit_cnt SHALL stay unchanged.
REQ-025 sctag_credit_ret with credit_cnt=JBI_RQ_CREDITS and no pop that cycle SHALL leave credit_cnt saturated and set credit_err.
REQ-026 A pop with credit_cnt=0 cannot occur (REQ-016); if an internal underflow is reached anyway, it SHALL set credit_err and clamp credit_cnt at 0.
REQ-027 credit_err SHALL stay 1 until reset.
REQ-028 csr_issue_stall asserted while in ISSUE SHALL NOT cancel the in-flight request; it SHALL block only the next pop.
REQ-029 issue_rdq_pop SHALL never be 1 when rdq_rd_en=0, so the RDQ never underflows.

Reset
REQ-030 While rst=1, the FSM SHALL be in IDLE, with issue_rdq_pop=0, sctag_req_vld=0, sctag_req=0, credit_cnt=JBI_RQ_CREDITS and credit_err=0.
REQ-031 Reset asserted in the ISSUE state SHALL drop sctag_req_vld immediately and discard the request; the popped RDQ entry is not replayed.
REQ-032 The first pop SHALL occur no earlier than the first clk edge after rst deasserts.

Structure
REQ-033 JBI_RQ_CREDITS, JBI_RDQ_WIDTH and the FSM state encodings SHALL live in the shared jbi package/header.
REQ-034 The credit counter SHALL be a separate sub-module, jbi_min_rq_credit_cnt, with inputs inc, dec, clk, rst and outputs cnt, err; the FSM and the datapath register SHALL stay in the top module.

Verification
REQ-035 Single request: rdq_rd_en=1 for one entry with rdq_dout=0x0123_4567_89AB_CDEF -> one pop at cycle N, sctag_req_vld=1 at N+1 with sctag_req=0x0123_4567_89AB_CDEF, credit_cnt 4->3.
REQ-036 Credit exhaustion: rdq_rd_en held at 1 with no credit returns -> exactly 4 pops on cycles N, N+2, N+4, N+6, then no pops and credit_cnt=0; one sctag_credit_ret -> exactly one more pop.
REQ-037 Simultaneous pop and credit return at credit_cnt=2 -> credit_cnt stays 2 and credit_err=0.
REQ-038 Overflow: sctag_credit_ret with credit_cnt=4 -> credit_cnt stays 4, credit_err=1 and stays 1 until rst.
REQ-039 Stall: csr_issue_stall=1 during an ISSUE cycle -> the current sctag_req_vld is still issued, and no further pop occurs until the stall clears.
REQ-040 Reset mid-issue: rst pulsed during ISSUE -> sctag_req_vld=0 immediately and credit_cnt=4 after reset, with no spurious pop.

Source files
------------

// File: rtl/jbi_min_rq_rdq_issue_pkg.sv
// Shared constants and FSM encoding for the RDQ-to-SCTAG request issue block.
package jbi_min_rq_rdq_issue_pkg;

  localparam int unsigned JBI_RQ_CREDITS = 4;
  localparam int unsigned JBI_RDQ_WIDTH  = 64;
  localparam int unsigned JBI_CNT_W      = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } issue_state_e;

endpackage

// File: rtl/jbi_min_rq_rdq_issue_if.sv
// Bus bundle between the RDQ/CSR/SCTAG side and the issue block.
interface jbi_min_rq_rdq_issue_if;
  import jbi_min_rq_rdq_issue_pkg::*;

  logic                     rdq_rd_en;
  logic [JBI_RDQ_WIDTH-1:0] rdq_dout;
  logic                     csr_issue_stall;
  logic                     sctag_credit_ret;
  logic                     issue_rdq_pop;
  logic                     sctag_req_vld;
  logic [JBI_RDQ_WIDTH-1:0] sctag_req;
  logic [JBI_CNT_W-1:0]     credit_cnt;
  logic                     credit_err;

  modport slave (
    input  rdq_rd_en, rdq_dout, csr_issue_stall, sctag_credit_ret,
    output issue_rdq_pop, sctag_req_vld, sctag_req, credit_cnt, credit_err
  );

  modport master (
    output rdq_rd_en, rdq_dout, csr_issue_stall, sctag_credit_ret,
    input  issue_rdq_pop, sctag_req_vld, sctag_req, credit_cnt, credit_err
  );
endinterface

// File: rtl/jbi_min_rq_rdq_issue_credit_cnt.sv
// Saturating SCTAG credit counter with a sticky overflow/underflow error flag.
module jbi_min_rq_credit_cnt
  import jbi_min_rq_rdq_issue_pkg::*;
#(
  parameter int unsigned MAX   = JBI_RQ_CREDITS,
  parameter int unsigned CNT_W = JBI_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Simultaneous inc/dec cancel; out-of-range moves clamp and latch the error.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (inc && !dec) begin
      if (cnt_q >= MAX_C) err_d = 1'b1;
      else                cnt_d = cnt_q + ONE_C;
    end else if (dec && !inc) begin
      if (cnt_q == '0)    err_d = 1'b1;
      else                cnt_d = cnt_q - ONE_C;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= MAX_C;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt = cnt_q;
  assign err = err_q;

endmodule

// File: rtl/jbi_min_rq_rdq_issue.sv
// Pops RDQ head entries and issues them to SCTAG, one request per two cycles, credit-limited.
module jbi_min_rq_rdq_issue
  import jbi_min_rq_rdq_issue_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  jbi_min_rq_rdq_issue_if.slave       bus
);

  issue_state_e             state_q;
  logic [JBI_RDQ_WIDTH-1:0] req_q;
  logic [JBI_CNT_W-1:0]     cnt;
  logic                     err;
  logic                     pop;

  // Pop is decided combinationally so the header is captured on the same edge.
  assign pop = !rst && (state_q == ST_IDLE) && bus.rdq_rd_en &&
               (cnt != '0) && !bus.csr_issue_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            req_q   <= bus.rdq_dout;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  jbi_min_rq_credit_cnt #(
    .MAX   (JBI_RQ_CREDITS),
    .CNT_W (JBI_CNT_W)
  ) u_credit_cnt (
    .clk (clk),
    .rst (rst),
    .inc (bus.sctag_credit_ret),
    .dec (pop),
    .cnt (cnt),
    .err (err)
  );

  assign bus.issue_rdq_pop = pop;
  assign bus.sctag_req_vld = (state_q == ST_ISSUE);
  assign bus.sctag_req     = req_q;
  assign bus.credit_cnt    = cnt;
  assign bus.credit_err    = err;

endmodule
